// File: rtl/control_entradas_pkg.sv
`timescale 1ns/1ps
// control_entradas_pkg
// Purpose: command codes shared between the input front end and the game FSM,
//          plus the rule that maps a button index to its command code.
// Ports:   none (package).
// Config:  none.
package control_entradas_pkg;

    localparam int CMD_NINGUNO   = 0;
    localparam int CMD_ARRIBA    = 1;
    localparam int CMD_ABAJO     = 2;
    localparam int CMD_IZQUIERDA = 3;
    localparam int CMD_DERECHA   = 4;
    localparam int CMD_PAUSA     = 5;

    // Button index 0 is the highest priority and maps to code 1; 0 means "no command".
    function automatic int codigo_de_indice(input int idx);
        return idx + 1;
    endfunction

endpackage

// File: rtl/control_entradas_antirrebote.sv
`timescale 1ns/1ps
// antirrebote
// Purpose: per-button front end: two-flop synchroniser, debouncer and press-edge detector.
// Ports:
//   clk          in   system clock
//   rst          in   synchronous reset, active-high
//   boton        in   raw asynchronous button level
//   estable_sig  out  debounced level as it will be after the next edge
//   pulso        out  one-cycle pulse while the debounced level has just risen
// Config: none.
module antirrebote #(
    parameter int DEB_CICLOS = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic boton,
    output logic estable_sig,
    output logic pulso
);

    localparam int CNT_W = $clog2(DEB_CICLOS + 1);

    logic             sinc1;
    logic             sinc2;
    logic             estable;
    logic             estable_d;
    logic [CNT_W-1:0] cnt;

    // The level is only accepted once the counter has seen DEB_CICLOS consecutive
    // disagreeing cycles, so the new level lands one edge after the count is reached.
    always_comb begin
        estable_sig = estable;
        if ((sinc2 != estable) && (cnt == CNT_W'(DEB_CICLOS)))
            estable_sig = sinc2;
    end

    // Synchroniser, debounce counter and delayed copy of the stable level.
    always_ff @(posedge clk) begin
        if (rst) begin
            sinc1     <= 1'b0;
            sinc2     <= 1'b0;
            estable   <= 1'b0;
            estable_d <= 1'b0;
            cnt       <= '0;
        end else begin
            sinc1     <= boton;
            sinc2     <= sinc1;
            estable   <= estable_sig;
            estable_d <= estable;
            if ((sinc2 == estable) || (cnt == CNT_W'(DEB_CICLOS)))
                cnt <= '0;
            else
                cnt <= cnt + CNT_W'(1);
        end
    end

    assign pulso = estable & ~estable_d;

endmodule

// File: rtl/control_entradas.sv
`timescale 1ns/1ps
// control_entradas
// Purpose: input front end for the game. Debounces the pushbuttons, reports the
//          highest-priority held button as a level code and queues press commands
//          for the game FSM through a valid/ready handshake.
// Ports:
//   clk          in   system clock
//   rst          in   synchronous reset, active-high
//   botones      in   raw buttons, index 0 = highest priority
//   boton_pres   out  code of highest-priority debounced held button, 0 if none
//   cmd_valid    out  queue head valid
//   cmd_code     out  queue head code, stable while waiting for cmd_ready
//   cmd_ready    in   consumer accepts the head when cmd_valid & cmd_ready
//   desborde     out  one-cycle pulse after an event was dropped on a full queue
//   nivel_fifo   out  queue occupancy
// Config: CONTROL_AUTOREPEAT_EN adds auto-repeat of the held highest-priority button
//         every REP_CICLOS cycles (never for the pause button).
module control_entradas
    import control_entradas_pkg::*;
#(
    parameter int N_BOTONES  = 5,
    parameter int CODE_W     = 3,
    parameter int DEB_CICLOS = 16,
    parameter int PROF_FIFO  = 4,
    parameter int REP_CICLOS = 1024
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_BOTONES-1:0]         botones,
    output logic [CODE_W-1:0]            boton_pres,
    output logic                         cmd_valid,
    output logic [CODE_W-1:0]            cmd_code,
    input  logic                         cmd_ready,
    output logic                         desborde,
    output logic [$clog2(PROF_FIFO):0]   nivel_fifo
);

    localparam int PTR_W = $clog2(PROF_FIFO);
    localparam int LVL_W = PTR_W + 1;

    // Parameter sanity: nothing is generated for a legal configuration.
    if (DEB_CICLOS < 1 || PROF_FIFO < 2 || REP_CICLOS < 1 || CODE_W < 1) begin : g_param_invalido
    end

    logic [N_BOTONES-1:0] estables_sig;
    logic [N_BOTONES-1:0] pulsos;
    logic [N_BOTONES-1:0] eventos;

    logic [CODE_W-1:0]    mem [PROF_FIFO];
    logic [PTR_W-1:0]     wr_ptr, rd_ptr, wr_sig, rd_sig;
    logic [LVL_W-1:0]     nivel_sig;
    logic [CODE_W-1:0]    push_code, code_sig;
    logic                 push, pop, lleno, do_push, rebose;

    function automatic logic [CODE_W-1:0] codificar(input logic [N_BOTONES-1:0] v);
        logic [CODE_W-1:0] c;
        c = '0;
        for (int i = N_BOTONES - 1; i >= 0; i--)
            if (v[i]) c = CODE_W'(codigo_de_indice(i));
        return c;
    endfunction

    for (genvar g = 0; g < N_BOTONES; g++) begin : g_boton
        antirrebote #(.DEB_CICLOS(DEB_CICLOS)) u_antirrebote (
            .clk         (clk),
            .rst         (rst),
            .boton       (botones[g]),
            .estable_sig (estables_sig[g]),
            .pulso       (pulsos[g])
        );
    end

`ifdef CONTROL_AUTOREPEAT_EN
    localparam int REP_W = $clog2(REP_CICLOS + 1);

    logic [CODE_W-1:0]    pres_d;
    logic [REP_W-1:0]     rep_cnt;
    logic                 rep_ev;
    logic [N_BOTONES-1:0] rep_vec;

    // A repeat fires only while the same non-pause button has stayed on top; it is
    // merged into the event vector so it obeys the normal priority and overflow rules.
    always_comb begin
        rep_ev = (boton_pres != '0) && (boton_pres == pres_d) &&
                 (boton_pres != CODE_W'(CMD_PAUSA)) &&
                 (rep_cnt == REP_W'(REP_CICLOS - 1));
        rep_vec = '0;
        for (int i = 0; i < N_BOTONES; i++)
            if (rep_ev && (boton_pres == CODE_W'(codigo_de_indice(i))))
                rep_vec[i] = 1'b1;
    end

    // Repeat timer restarts on release, on a change of top button and after each repeat.
    always_ff @(posedge clk) begin
        if (rst) begin
            pres_d  <= '0;
            rep_cnt <= '0;
        end else begin
            pres_d <= boton_pres;
            if ((boton_pres == '0) || (boton_pres != pres_d) || rep_ev)
                rep_cnt <= '0;
            else
                rep_cnt <= rep_cnt + REP_W'(1);
        end
    end

    assign eventos = pulsos | rep_vec;
`else
    assign eventos = pulsos;
`endif

    // Queue next-state. The head register is loaded with the entry that will be at
    // the head after this edge; if that entry is being written now, take it directly.
    always_comb begin
        push_code = codificar(eventos);
        push      = |eventos;
        pop       = cmd_valid & cmd_ready;
        lleno     = (nivel_fifo == LVL_W'(PROF_FIFO));
        do_push   = push && (!lleno || pop);
        rebose    = push && lleno && !pop;
        rd_sig    = pop     ? rd_ptr + PTR_W'(1) : rd_ptr;
        wr_sig    = do_push ? wr_ptr + PTR_W'(1) : wr_ptr;
        nivel_sig = nivel_fifo;
        if (do_push && !pop)
            nivel_sig = nivel_fifo + LVL_W'(1);
        else if (!do_push && pop)
            nivel_sig = nivel_fifo - LVL_W'(1);
        if (nivel_sig == '0)
            code_sig = '0;
        else if (do_push && (rd_sig == wr_ptr))
            code_sig = push_code;
        else
            code_sig = mem[rd_sig];
    end

    // Queue storage needs no reset: entries are only read once written.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= push_code;
    end

    // Control registers and the registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            nivel_fifo <= '0;
            cmd_valid  <= 1'b0;
            cmd_code   <= '0;
            desborde   <= 1'b0;
            boton_pres <= '0;
        end else begin
            wr_ptr     <= wr_sig;
            rd_ptr     <= rd_sig;
            nivel_fifo <= nivel_sig;
            cmd_valid  <= (nivel_sig != '0);
            cmd_code   <= code_sig;
            desborde   <= rebose;
            boton_pres <= codificar(estables_sig);
        end
    end

endmodule

// File: tb/tb_control_entradas.sv
`timescale 1ns/1ps
// tb_control_entradas
// Purpose: self-checking bench for control_entradas with DEB_CICLOS=4, PROF_FIFO=4,
//          REP_CICLOS=16. Expected command codes go into a scoreboard queue when the
//          presses are driven and are compared on every accepted handshake.
// Config: CONTROL_AUTOREPEAT_EN changes the expected number of events for long holds.
module tb_control_entradas;

    localparam int N    = 5;
    localparam int CW   = 3;
    localparam int DEB  = 4;
    localparam int PF   = 4;
    localparam int REP  = 16;
    localparam int LW   = $clog2(PF) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  botones;
    logic [CW-1:0] boton_pres;
    logic          cmd_valid;
    logic [CW-1:0] cmd_code;
    logic          cmd_ready;
    logic          desborde;
    logic [LW-1:0] nivel_fifo;

    int            checks   = 0;
    int            errors   = 0;
    int            desb_cnt = 0;
    int            hs_cnt   = 0;
    time           hs_t[$];
    logic [CW-1:0] exp_q[$];

    control_entradas #(
        .N_BOTONES (N),
        .CODE_W    (CW),
        .DEB_CICLOS(DEB),
        .PROF_FIFO (PF),
        .REP_CICLOS(REP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .botones   (botones),
        .boton_pres(boton_pres),
        .cmd_valid (cmd_valid),
        .cmd_code  (cmd_code),
        .cmd_ready (cmd_ready),
        .desborde  (desborde),
        .nivel_fifo(nivel_fifo)
    );

    always #5 clk = ~clk;

    // Single comparison point: counts the check and reports any difference.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Inputs change 2 ns after a rising edge; outputs are sampled on falling edges.
    task automatic applyStimulus(input logic [N-1:0] b, input logic r);
        @(posedge clk);
        #2;
        botones   = b;
        cmd_ready = r;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic waitDrain(input string tag);
        for (int i = 0; i < 40 && (nivel_fifo != '0 || exp_q.size() != 0); i++)
            @(negedge clk);
        checkOutput({tag, "_nivel"}, nivel_fifo, 0);
        checkOutput({tag, "_sb"}, exp_q.size(), 0);
    endtask

    task automatic pressRelease(input int idx, input logic r);
        applyStimulus(N'(1) << idx, r);
        waitCycles(8);
        applyStimulus('0, r);
        waitCycles(8);
    endtask

    // Scoreboard consumer: every accepted head is compared with the oldest expectation.
    always @(negedge clk) begin
        if (desborde === 1'b1)
            desb_cnt++;
        if (rst === 1'b0 && cmd_valid === 1'b1 && cmd_ready === 1'b1) begin
            hs_cnt++;
            hs_t.push_back($time);
            if (exp_q.size() == 0)
                checkOutput("sb_extra_cmd", cmd_code, 0);
            else
                checkOutput("sb_cmd_code", cmd_code, exp_q.pop_front());
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int d0;
        int h0;
        int orden[5];
        orden = '{3, 1, 4, 0, 2};

        rst       = 1'b1;
        botones   = '0;
        cmd_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_boton_pres", boton_pres, 0);
        checkOutput("rst_cmd_valid", cmd_valid, 0);
        checkOutput("rst_cmd_code", cmd_code, 0);
        checkOutput("rst_desborde", desborde, 0);
        checkOutput("rst_nivel", nivel_fifo, 0);
        @(posedge clk);
        #2 rst = 1'b0;
        waitCycles(3);

        // Test 1: single press, exact latency, release timing.
        exp_q.push_back(3'd1);
        applyStimulus(5'b00001, 1'b1);
        waitCycles(7);
        checkOutput("t1_pres_early", boton_pres, 0);
        checkOutput("t1_valid_early", cmd_valid, 0);
        waitCycles(1);
        checkOutput("t1_pres_held", boton_pres, 1);
        checkOutput("t1_valid_before", cmd_valid, 0);
        waitCycles(1);
        checkOutput("t1_valid", cmd_valid, 1);
        checkOutput("t1_code", cmd_code, 1);
        @(posedge clk);
        applyStimulus('0, 1'b1);
        waitCycles(7);
        checkOutput("t1_pres_release_early", boton_pres, 1);
        waitCycles(1);
        checkOutput("t1_pres_released", boton_pres, 0);
        checkOutput("t1_nivel", nivel_fifo, 0);

        // Test 2: glitch shorter than the debounce window.
        h0 = hs_cnt;
        repeat (3) applyStimulus(5'b00100, 1'b1);
        applyStimulus('0, 1'b1);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            checkOutput("t2_pres", boton_pres, 0);
            checkOutput("t2_valid", cmd_valid, 0);
        end
        checkOutput("t2_no_cmd", hs_cnt - h0, 0);

        // Test 3: two buttons in the same cycle give one entry with the higher priority.
        exp_q.push_back(3'd2);
        applyStimulus(5'b01010, 1'b0);
        waitCycles(12);
        checkOutput("t3_nivel", nivel_fifo, 1);
        checkOutput("t3_pres", boton_pres, 2);
        checkOutput("t3_code", cmd_code, 2);
        applyStimulus('0, 1'b0);
        waitCycles(10);
        checkOutput("t3_pres_released", boton_pres, 0);
        checkOutput("t3_nivel_after_release", nivel_fifo, 1);
        applyStimulus('0, 1'b1);
        waitDrain("t3_drain");

        // Test 4: overflow on the fifth press, then FIFO-order drain.
        d0 = desb_cnt;
        for (int k = 0; k < 5; k++) begin
            if (k < 4)
                exp_q.push_back(CW'(orden[k] + 1));
            pressRelease(orden[k], 1'b0);
        end
        checkOutput("t4_desborde_pulses", desb_cnt - d0, 1);
        checkOutput("t4_nivel_full", nivel_fifo, 4);
        checkOutput("t4_head", cmd_code, 4);
        applyStimulus('0, 1'b1);
        waitDrain("t4_drain");

        // Test 5: push and pop in the same cycle on a full queue.
        d0 = desb_cnt;
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back(CW'(k + 1));
            pressRelease(k, 1'b0);
        end
        checkOutput("t5_nivel_full", nivel_fifo, 4);
        exp_q.push_back(3'd5);
        applyStimulus(5'b10000, 1'b0);
        repeat (7) @(posedge clk);
        #2 cmd_ready = 1'b1;
        @(posedge clk);
        #2 cmd_ready = 1'b0;
        waitCycles(2);
        checkOutput("t5_nivel_kept", nivel_fifo, 4);
        checkOutput("t5_no_desborde", desb_cnt - d0, 0);
        checkOutput("t5_head", cmd_code, 2);
        applyStimulus('0, 1'b0);
        waitCycles(8);
        applyStimulus('0, 1'b1);
        waitDrain("t5_drain");

        // Test 6: reset while a button is still being debounced.
        exp_q.push_back(3'd2);
        applyStimulus(5'b00010, 1'b0);
        waitCycles(10);
        checkOutput("t6_nivel_pre", nivel_fifo, 1);
        checkOutput("t6_pres_pre", boton_pres, 2);
        applyStimulus(5'b00011, 1'b0);
        waitCycles(2);
        @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("t6_rst_pres", boton_pres, 0);
        checkOutput("t6_rst_valid", cmd_valid, 0);
        checkOutput("t6_rst_code", cmd_code, 0);
        checkOutput("t6_rst_nivel", nivel_fifo, 0);
        checkOutput("t6_rst_desborde", desborde, 0);
        exp_q.delete();
        exp_q.push_back(3'd1);
        @(posedge clk);
        #2 rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checkOutput("t6_valid_early", cmd_valid, 0);
        end
        for (int i = 0; i < 20 && cmd_valid !== 1'b1; i++)
            @(negedge clk);
        checkOutput("t6_valid", cmd_valid, 1);
        checkOutput("t6_code", cmd_code, 1);
        checkOutput("t6_nivel", nivel_fifo, 1);
        applyStimulus('0, 1'b0);
        waitCycles(8);
        applyStimulus('0, 1'b1);
        waitDrain("t6_drain");

        // Test 7: long holds (repeat behaviour depends on the build).
        h0 = hs_cnt;
        exp_q.push_back(3'd1);
`ifdef CONTROL_AUTOREPEAT_EN
        exp_q.push_back(3'd1);
        exp_q.push_back(3'd1);
`endif
        applyStimulus(5'b00001, 1'b1);
        waitCycles(40);
        applyStimulus('0, 1'b1);
        waitCycles(12);
`ifdef CONTROL_AUTOREPEAT_EN
        checkOutput("t7_repeat_count", hs_cnt - h0, 3);
        if (hs_cnt - h0 >= 3) begin
            checkOutput("t7_spacing_1", 32'(hs_t[h0 + 1] - hs_t[h0]), 160);
            checkOutput("t7_spacing_2", 32'(hs_t[h0 + 2] - hs_t[h0 + 1]), 160);
        end
`else
        checkOutput("t7_single_event", hs_cnt - h0, 1);
`endif
        h0 = hs_cnt;
        exp_q.push_back(3'd5);
        applyStimulus(5'b10000, 1'b1);
        waitCycles(40);
        applyStimulus('0, 1'b1);
        waitCycles(12);
        checkOutput("t7_pause_single", hs_cnt - h0, 1);

        checkOutput("end_sb_empty", exp_q.size(), 0);
        checkOutput("end_nivel", nivel_fifo, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
